spi_segment_master: RTL and testbench
=====================================

// Module: spi_segment_master
// PURPOSE
//  SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) that drives the serial
//  input of the SPI segment controller. It takes bytes through a
//  valid/ready handshake and shifts them out on sclk/mosi/cs_n.
//  Used as the on-chip/FPGA-side driver and as the stimulus source in
//  controller-level benches.
// PARAMETERS
//  CLK_DIV  2  clk cycles per sclk half-period (legal range 1..255)
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  tx_data    in   8  byte to send; sampled only on accept
//  tx_last    in   1  sampled with tx_data; 1 = release cs_n after this byte
//  tx_valid   in   1  byte offered
//  tx_ready   out  1  block can accept a byte this cycle
//  spi_sclk   out  1  serial clock
//  spi_mosi   out  1  serial data, changes only while sclk is low
//  spi_cs_n   out  1  chip select, active low
//  busy       out  1  1 whenever state != IDLE
//  done       out  1  one-cycle pulse when cs_n deasserts after a last byte
// BEHAVIOUR
//  - Interface: one clock (clk). Reset (rst) is synchronous and
//    active-high.
//  - Reset values, effective the cycle after rst is sampled high
//    (including mid-transfer):
//    state=IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, tx_ready=1, busy=0,
//    done=0, all counters=0. A partial byte is discarded; no done pulse.
//  - Accept = tx_valid & tx_ready in the same cycle. tx_valid while tx_ready=0
//    is ignored (no queuing).
//  - All outputs are registered. Cycle numbers below are relative to the
//    accept cycle (cycle 0).
//  - States: IDLE, LEAD, SCK_HI, SCK_LO, NEXT, TAIL, GAP.
//  - IDLE: tx_ready=1, cs_n=1, sclk=0. On accept: latch tx_data and tx_last,
//    bit_cnt=0 -> LEAD.
//    From cycle 1: cs_n=0, mosi=data[7], tx_ready=0.
//  - LEAD: hold for CLK_DIV cycles with sclk=0 -> SCK_HI.
//  - SCK_HI: sclk=1 for CLK_DIV cycles (slave samples on the rising edge)
//    -> SCK_LO.
//  - SCK_LO: on entry sclk=0 and the shift register shifts left, so mosi
//    shows the next bit. Hold for CLK_DIV cycles, then:
//    - bit_cnt<7: bit_cnt++ -> SCK_HI.
//    - bit_cnt==7, latched last=1 -> TAIL.
//    - bit_cnt==7, latched last=0 -> NEXT.
//  - NEXT: cs_n stays 0, sclk=0, tx_ready=1. Stalls indefinitely until an
//    accept arrives.
//    On accept: latch the new byte, bit_cnt=0, mosi=data[7], then -> SCK_HI
//    after CLK_DIV cycles of sclk low (same setup time as LEAD).
//  - TAIL: cs_n=0, sclk=0 for CLK_DIV cycles. Then cs_n=1 and done=1 for
//    exactly one cycle -> GAP.
//  - GAP: cs_n=1 for CLK_DIV cycles (minimum deselect time) -> IDLE.
//  - Bit period = 2*CLK_DIV clk. Exactly 8 rising sclk edges per byte; sclk
//    idles low.
//  - The half-period counter is 8 bits. It counts CLK_DIV-1 down to 0 and
//    reloads on every state change; it never wraps.
//  - rst has priority over accept in the same cycle.
// TESTING
//  1 CLK_DIV=2, send 0xA5 with last=1 at cycle 0 -> cs_n low cycles 1..36;
//    sclk rising edges at cycles 3,7,...,31; mosi sampled 1,0,1,0,0,1,0,1;
//    done=1 at cycle 37 only; tx_ready=1 again at cycle 39.
//  2 Send 0x3C (last=0) then 0xFF (last=1), tx_valid held high -> 16 rising
//    edges, cs_n stays low between bytes; mosi stream 0x3C,0xFF; one done
//    pulse.
//  3 Send 0x81 (last=0), tx_valid low for 50 cycles in NEXT -> sclk low,
//    cs_n low, tx_ready=1 throughout; then 0x01 (last=1) completes normally.
//  4 rst=1 after the 4th rising edge -> next cycle cs_n=1, sclk=0, busy=0,
//    no done. Then a fresh 0x55 transfers correctly.
//  5 CLK_DIV=1, send 0x00 with last=1 -> byte spans 16 clk cycles; sclk
//    toggles every cycle; mosi=0 throughout.
//  6 tx_valid pulsed with 0xEE while busy=1 and tx_ready=0 -> ignored; only
//    the original byte appears on mosi.

Source files
------------

// File: rtl/spi_segment_master.sv
// SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) with a valid/ready byte
// interface; cs_n is held across bytes until a byte flagged last completes.
module spi_segment_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, LEAD, SCK_HI, SCK_LO, NEXT, TAIL, GAP
  } state_e;

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       last_q, last_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       accept;

  assign accept = tx_valid & ready_q;

  // Outputs are computed for the state being entered so they register in
  // the same edge as the state itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, NEXT: begin
        if (accept) begin
          state_d = LEAD;
          cnt_d   = RELOAD;
          shreg_d = tx_data;
          last_d  = tx_last;
          bit_d   = 3'd0;
          mosi_d  = tx_data[7];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
        end
      end
      LEAD: begin
        if (cnt_q == 8'd0) begin
          state_d = SCK_HI;
          cnt_d   = RELOAD;
          sclk_d  = 1'b1;
        end
      end
      SCK_HI: begin
        if (cnt_q == 8'd0) begin
          state_d = SCK_LO;
          cnt_d   = RELOAD;
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[6:0], 1'b0};
          mosi_d  = shreg_q[6];
        end
      end
      SCK_LO: begin
        if (cnt_q == 8'd0) begin
          cnt_d = RELOAD;
          if (bit_q != 3'd7) begin
            state_d = SCK_HI;
            bit_d   = bit_q + 3'd1;
            sclk_d  = 1'b1;
          end else if (last_q) begin
            state_d = TAIL;
          end else begin
            state_d = NEXT;
            ready_d = 1'b1;
          end
        end
      end
      TAIL: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = RELOAD;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = RELOAD;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = ready_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_segment_master.sv
// Bench for spi_segment_master: a bit-level SPI receiver model rebuilds bytes
// from sclk/mosi and compares them with the bytes handed to the master.
module tb_spi_segment_master;

  localparam int unsigned DA = 2;
  localparam int unsigned DB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_last, a_valid, a_ready, a_sclk, a_mosi, a_cs_n, a_busy, a_done;
  logic [7:0] a_data;
  logic       b_rst, b_last, b_valid, b_ready, b_sclk, b_mosi, b_cs_n, b_busy, b_done;
  logic [7:0] b_data;

  spi_segment_master #(.CLK_DIV(DA)) dut_a (
    .clk(clk), .rst(a_rst), .tx_data(a_data), .tx_last(a_last), .tx_valid(a_valid),
    .tx_ready(a_ready), .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_cs_n(a_cs_n),
    .busy(a_busy), .done(a_done));

  spi_segment_master #(.CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(b_rst), .tx_data(b_data), .tx_last(b_last), .tx_valid(b_valid),
    .tx_ready(b_ready), .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_cs_n(b_cs_n),
    .busy(b_busy), .done(b_done));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI slave model: samples mosi on every sclk rising edge.
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  sh = '0;
  int unsigned nbits = 0, rises = 0, dones = 0, frames = 0;
  int unsigned viol_cs = 0, viol_mosi = 0, viol_done = 0;
  logic        prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1;

  always @(negedge clk) begin
    if (a_sclk && !prev_sclk) begin
      rises++;
      if (a_cs_n) viol_cs++;
      sh = {sh[6:0], a_mosi};
      nbits++;
      if (nbits == 8) begin
        rx_q.push_back(sh);
        nbits = 0;
      end
    end
    if (a_sclk && prev_sclk && a_mosi !== prev_mosi) viol_mosi++;
    if (a_done) begin
      dones++;
      if (!(a_cs_n && !prev_cs)) viol_done++;
    end
    prev_sclk = a_sclk;
    prev_mosi = a_mosi;
    prev_cs   = a_cs_n;
  end

  always @(posedge clk) if (a_rst) nbits = 0;

  task automatic send(input logic [7:0] d, input logic l, input bit hold);
    int unsigned n = 0;
    @(negedge clk);
    a_data = d; a_last = l; a_valid = 1'b1;
    while (!a_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      check("send_timeout", 0, 1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(d);
    @(negedge clk);
    if (!hold) a_valid = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (!a_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", a_done, 1);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
    frames++;
  endtask

  initial begin
    int unsigned nrise, first_rise, last_rise, cs_low, cs_hi_rel, done_rel, ndone, ready_rel;
    int unsigned viol, r0, mosi_ones, nb;
    logic ps, prev_hold;

    a_rst = 1'b1; a_data = '0; a_last = 1'b0; a_valid = 1'b0;
    b_rst = 1'b1; b_data = '0; b_last = 1'b0; b_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", a_cs_n, 1);
    check("rst_sclk", a_sclk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_ready", a_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    a_rst = 1'b0; b_rst = 1'b0;

    // Single byte, exact cycle timing relative to the accept cycle.
    send(8'hA5, 1'b1, 1'b0);
    nrise = 0; first_rise = 0; last_rise = 0; cs_low = 0; cs_hi_rel = 0;
    done_rel = 0; ndone = 0; ready_rel = 0; ps = 1'b0;
    check("t1_mosi_rel1", a_mosi, 1);
    check("t1_busy_rel1", a_busy, 1);
    for (int rel = 1; rel <= 45; rel++) begin
      if (a_sclk && !ps) begin
        if (nrise == 0) first_rise = rel;
        last_rise = rel;
        nrise++;
      end
      if (!a_cs_n) cs_low++;
      else if (cs_hi_rel == 0) cs_hi_rel = rel;
      if (a_done) begin done_rel = rel; ndone++; end
      if (a_ready && ready_rel == 0) ready_rel = rel;
      ps = a_sclk;
      @(negedge clk);
    end
    check("t1_rises", nrise, 8);
    check("t1_first_rise", first_rise, 1 + DA);
    check("t1_last_rise", last_rise, 1 + 15 * DA);
    check("t1_cs_low_cycles", cs_low, 18 * DA);
    check("t1_cs_high_rel", cs_hi_rel, 1 + 18 * DA);
    check("t1_done_rel", done_rel, 1 + 18 * DA);
    check("t1_done_count", ndone, 1);
    check("t1_ready_rel", ready_rel, 1 + 19 * DA);
    compare_frame("t1");

    // Two bytes back-to-back with tx_valid held high.
    r0 = rises;
    send(8'h3C, 1'b0, 1'b1);
    send(8'hFF, 1'b1, 1'b0);
    wait_done();
    check("t2_rises", rises - r0, 16);
    compare_frame("t2");

    // Stall in NEXT for 50 cycles with no byte offered.
    send(8'h81, 1'b0, 1'b0);
    viol = 0;
    for (int n = 0; n < 2000 && !a_ready; n++) @(negedge clk);
    check("t3_next_ready", a_ready, 1);
    for (int n = 0; n < 50; n++) begin
      if (a_sclk !== 1'b0 || a_cs_n !== 1'b0 || a_ready !== 1'b1) viol++;
      @(negedge clk);
    end
    check("t3_stall_violations", viol, 0);
    send(8'h01, 1'b1, 1'b0);
    wait_done();
    compare_frame("t3");

    // Reset after the fourth rising edge discards the partial byte.
    send(8'h96, 1'b1, 1'b0);
    nrise = 0; ps = 1'b0;
    for (int n = 0; n < 200 && nrise < 4; n++) begin
      if (a_sclk && !ps) nrise++;
      ps = a_sclk;
      if (nrise < 4) @(negedge clk);
    end
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    check("t4_cs_n", a_cs_n, 1);
    check("t4_sclk", a_sclk, 0);
    check("t4_busy", a_busy, 0);
    check("t4_done", a_done, 0);
    check("t4_ready", a_ready, 1);
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      if (a_done) ndone++;
      @(negedge clk);
    end
    check("t4_no_done", ndone, 0);
    check("t4_no_partial", rx_q.size(), 0);
    exp_q.delete();
    send(8'h55, 1'b1, 1'b0);
    wait_done();
    compare_frame("t4");

    // CLK_DIV=1 instance: zero byte, sclk toggles every cycle.
    @(negedge clk);
    b_data = 8'h00; b_last = 1'b1; b_valid = 1'b1;
    check("t5_ready", b_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    nrise = 0; first_rise = 0; last_rise = 0; cs_low = 0; done_rel = 0; mosi_ones = 0; ps = 1'b0;
    for (int rel = 1; rel <= 25; rel++) begin
      if (b_sclk && !ps) begin
        if (nrise == 0) first_rise = rel;
        last_rise = rel;
        nrise++;
      end
      if (!b_cs_n) begin
        cs_low++;
        if (b_mosi) mosi_ones++;
      end
      if (b_done) done_rel = rel;
      ps = b_sclk;
      @(negedge clk);
    end
    check("t5_rises", nrise, 8);
    check("t5_first_rise", first_rise, 1 + DB);
    check("t5_last_rise", last_rise, 1 + 15 * DB);
    check("t5_cs_low_cycles", cs_low, 18 * DB);
    check("t5_done_rel", done_rel, 1 + 18 * DB);
    check("t5_mosi_ones", mosi_ones, 0);

    // A byte offered while busy must be ignored.
    send(8'hC3, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("t6_ready_low", a_ready, 0);
    a_data = 8'hEE; a_last = 1'b1; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    wait_done();
    compare_frame("t6");
    repeat (30) @(negedge clk);
    check("t6_idle_after", a_busy, 0);
    check("t6_no_extra", rx_q.size(), 0);

    // Random multi-byte frames with random handshake gaps.
    for (int f = 0; f < 8; f++) begin
      nb = $urandom_range(1, 4);
      prev_hold = 1'b0;
      for (int b = 0; b < int'(nb); b++) begin
        logic l;
        bit   hold;
        l = (b == int'(nb) - 1);
        hold = !l && ($urandom_range(0, 1) == 1);
        if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        send(8'($urandom), l, hold);
        prev_hold = hold;
      end
      wait_done();
      compare_frame("rand");
    end

    repeat (10) @(negedge clk);
    check("done_pulses", dones, frames);
    check("cs_during_rise", viol_cs, 0);
    check("mosi_stable_high", viol_mosi, 0);
    check("done_at_cs_release", viol_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
